// File: rtl/sevseg_scan.sv
// Four-digit multiplexed seven-segment scanner with dead time between digit slots.
// All outputs registered; inputs are captured once per frame as the first digit slot begins.
module sevseg_scan #(
    parameter int REFRESH_CYCLES = 100000,
    parameter int DEAD_CYCLES    = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] digits_i,
    input  logic [3:0]  blank_i,
    input  logic [3:0]  dp_i,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        frame_o
);

    localparam int MAX_CYC = (REFRESH_CYCLES > DEAD_CYCLES) ? REFRESH_CYCLES : DEAD_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] DEAD_LAST    = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);

    typedef enum logic {S_DEAD, S_ON} state_t;

    state_t        state, state_n;
    logic [1:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   sh_digits, sh_digits_n;
    logic [3:0]    sh_blank, sh_blank_n;
    logic [3:0]    sh_dp, sh_dp_n;
    logic [3:0]    an_n;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic          frame_n;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Outputs are computed here for the state being entered, so the output
    // registers toggle on exactly the edge where the FSM changes state.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        cnt_n       = cnt + CW'(1);
        sh_digits_n = sh_digits;
        sh_blank_n  = sh_blank;
        sh_dp_n     = sh_dp;
        an_n        = an_o;
        seg_n       = seg_o;
        dp_n        = dp_o;
        frame_n     = 1'b0;
        case (state)
            S_DEAD: begin
                if (cnt == DEAD_LAST) begin
                    state_n = S_ON;
                    cnt_n   = '0;
                    if (idx == 2'd0) begin
                        sh_digits_n = digits_i;
                        sh_blank_n  = blank_i;
                        sh_dp_n     = dp_i;
                    end
                    if (!sh_blank_n[idx]) begin
                        an_n  = ~(4'b0001 << idx);
                        seg_n = decode(sh_digits_n[{idx, 2'b00} +: 4]);
                        dp_n  = ~sh_dp_n[idx];
                    end else begin
                        an_n  = 4'hF;
                        seg_n = 7'h7F;
                        dp_n  = 1'b1;
                    end
                end
            end
            default: begin
                if (cnt == REFRESH_LAST) begin
                    state_n = S_DEAD;
                    cnt_n   = '0;
                    idx_n   = idx + 2'd1;
                    frame_n = (idx == 2'd3);
                    an_n    = 4'hF;
                    seg_n   = 7'h7F;
                    dp_n    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_DEAD;
            idx       <= 2'd0;
            cnt       <= '0;
            sh_digits <= '0;
            sh_blank  <= '0;
            sh_dp     <= '0;
            an_o      <= 4'hF;
            seg_o     <= 7'h7F;
            dp_o      <= 1'b1;
            frame_o   <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            sh_digits <= sh_digits_n;
            sh_blank  <= sh_blank_n;
            sh_dp     <= sh_dp_n;
            an_o      <= an_n;
            seg_o     <= seg_n;
            dp_o      <= dp_n;
            frame_o   <= frame_n;
        end
    end

endmodule

// File: tb/tb_sevseg_scan.sv
// Directed bench for sevseg_scan with REFRESH_CYCLES=4, DEAD_CYCLES=2 (24-cycle frame).
module tb_sevseg_scan;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] digits_i;
    logic [3:0]  blank_i;
    logic [3:0]  dp_i;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_o;

    sevseg_scan #(.REFRESH_CYCLES(4), .DEAD_CYCLES(2)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .digits_i (digits_i),
        .blank_i  (blank_i),
        .dp_i     (dp_i),
        .an_o     (an_o),
        .seg_o    (seg_o),
        .dp_o     (dp_o),
        .frame_o  (frame_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      blank;
        logic [3:0]      dp;
        logic [15:0]     dist_digits;
        logic [3:0][3:0] an;
        logic [3:0][6:0] seg;
        logic [3:0]      dpo;
    } vec_t;

    vec_t vec [6];
    int   nvec = 0;
    int   nbad = 0;

    task automatic check(input string name, input int a, input int b,
                         input logic [3:0] ean, input logic [6:0] eseg,
                         input logic edp, input logic efr);
        nvec++;
        if (an_o !== ean || seg_o !== eseg || dp_o !== edp || frame_o !== efr) begin
            nbad++;
            $display("FAIL %s %0d/%0d: got an=%h seg=%h dp=%b frame=%b, want an=%h seg=%h dp=%b frame=%b",
                     name, a, b, an_o, seg_o, dp_o, frame_o, ean, eseg, edp, efr);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Runs cycles 0..stop-1 of one frame; cycle 0 is the current sample.
    task automatic run_frame(input int r, input bit first, input int stop);
        for (int c = 0; c < stop; c++) begin
            int slot;
            int pos;
            slot = c / 6;
            pos  = c % 6;
            if (pos < 2)
                check("frame", r, c, 4'hF, 7'h7F, 1'b1, (c == 0) && !first);
            else
                check("frame", r, c, vec[r].an[slot], vec[r].seg[slot], vec[r].dpo[slot], 1'b0);
            if (c == 0) begin
                digits_i = vec[r].digits;
                blank_i  = vec[r].blank;
                dp_i     = vec[r].dp;
            end else if (c == 8) begin
                digits_i = vec[r].dist_digits;
                blank_i  = ~vec[r].blank;
                dp_i     = ~vec[r].dp;
            end
            step();
        end
    endtask

    initial begin
        vec[0] = '{16'h1234, 4'h0, 4'h0, 16'hABCD, {4'h7, 4'hB, 4'hD, 4'hE},
                   {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
        vec[1] = '{16'hABCD, 4'h0, 4'h0, 16'h1234, {4'h7, 4'hB, 4'hD, 4'hE},
                   {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF};
        vec[2] = '{16'h5678, 4'b0100, 4'h0, 16'hFFFF, {4'h7, 4'hF, 4'hD, 4'hE},
                   {7'h12, 7'h7F, 7'h78, 7'h00}, 4'hF};
        vec[3] = '{16'h9EF0, 4'h0, 4'b0001, 16'h0000, {4'h7, 4'hB, 4'hD, 4'hE},
                   {7'h10, 7'h06, 7'h0E, 7'h40}, 4'hE};
        vec[4] = '{16'h0000, 4'hF, 4'hF, 16'h8888, {4'hF, 4'hF, 4'hF, 4'hF},
                   {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF};
        vec[5] = '{16'h1357, 4'h0, 4'b1010, 16'h2468, {4'h7, 4'hB, 4'hD, 4'hE},
                   {7'h79, 7'h30, 7'h12, 7'h78}, 4'h5};

        // Reset held three cycles with arbitrary inputs.
        rst_i    = 1'b1;
        digits_i = 16'hBEEF;
        blank_i  = 4'h5;
        dp_i     = 4'hA;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset", i, 0, 4'hF, 7'h7F, 1'b1, 1'b0);
        end
        rst_i = 1'b0;

        for (int r = 0; r < 6; r++)
            run_frame(r, r == 0, 24);

        // Reset pulse in the middle of digit 2, then a clean frame with new inputs.
        run_frame(3, 1'b0, 14);
        check("mid_d2", 3, 14, 4'hB, 7'h06, 1'b1, 1'b0);
        rst_i    = 1'b1;
        digits_i = vec[0].digits;
        blank_i  = vec[0].blank;
        dp_i     = vec[0].dp;
        step();
        check("rst_pulse", 0, 0, 4'hF, 7'h7F, 1'b1, 1'b0);
        rst_i = 1'b0;
        run_frame(0, 1'b1, 24);
        run_frame(1, 1'b0, 24);
        check("after", 1, 24, 4'hF, 7'h7F, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
